// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared types and constants for the bit-serial adder
// Contents:
//   state_t        FSM state encoding (IDLE, RUN, DONE)
//   DEFAULT_WIDTH  default operand/result width in bits
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_adder_cell.sv
// rtl/full_adder_cell.sv - one-bit full adder used by the serial datapath
// Ports:
//   a, b   input  operand bits
//   c      input  carry in
//   sum    output sum bit
//   carry  output carry out
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial add/subtract, one bit pair per clock, LSB first
// Ports:
//   clk    input         clock, all state on rising edge
//   rst    input         asynchronous active-high reset
//   start  input         request new operation (accepted in IDLE or DONE)
//   sub    input         0 = a+b, 1 = a-b, sampled with start
//   a, b   input  WIDTH  operands, sampled with start
//   busy   output        high while bits are being processed
//   done   output        one-cycle pulse when a result completes
//   sum    output WIDTH  result of last completed operation
//   cout   output        carry out of MSB (sub mode: 1 = no borrow)
//   ovf    output        signed overflow, only when SERIAL_ADDER_OVF_EN is defined
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             cout,
    output logic             ovf
`else
    output logic             cout
`endif
);

    localparam int CW = ($clog2(WIDTH) < 1) ? 1 : $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             s_bit;
    logic             c_bit;
    logic [WIDTH-1:0] res_next;

    full_adder_cell u_fa (
        .a     (a_sh[0]),
        .b     (b_sh[0]),
        .c     (carry),
        .sum   (s_bit),
        .carry (c_bit)
    );

    // New sum bit enters at the MSB so that after WIDTH shifts bit 0 sits at bit 0.
    assign res_next = {s_bit, res_sh[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf    <= 1'b0;
`endif
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        // Subtraction is a + ~b + 1: invert b and seed the carry.
                        a_sh  <= a;
                        b_sh  <= b ^ {WIDTH{sub}};
                        carry <= sub;
                        cnt   <= '0;
                        state <= RUN;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= res_next;
                    carry  <= c_bit;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        sum   <= res_next;
                        cout  <= c_bit;
`ifdef SERIAL_ADDER_OVF_EN
                        // Stored carry at this point is the carry into the MSB.
                        ovf   <= carry ^ c_bit;
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed self-checking bench for serial_adder
module tb_serial_adder;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             sub = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;
`endif

    int total = 0;
    int bad = 0;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
`ifdef SERIAL_ADDER_OVF_EN
        .cout  (cout),
        .ovf   (ovf)
`else
        .cout  (cout)
`endif
    );

    always #5 clk = ~clk;

    // Stimulus only: issue one operation from a point 1 time unit after an edge,
    // then sample for WIDTH+4 cycles, counting busy and done cycles.
    task automatic do_op(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                         input logic isub, output int nbusy, output int ndone);
        a = ia;
        b = ib;
        sub = isub;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        nbusy = 0;
        ndone = 0;
        for (int i = 0; i < WIDTH + 4; i++) begin
            if (busy) nbusy++;
            if (done) ndone++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({busy, done, sum, cout} !== {2'b00, 8'h00, 1'b0}) begin
            bad++;
            $display("FAIL reset_state: got busy=%b done=%b sum=%h cout=%b want all 0",
                     busy, done, sum, cout);
        end
        rst = 1'b0;
    endtask

    task automatic test_add;
        logic [WIDTH-1:0] va [4] = '{8'h0F, 8'hFF, 8'h12, 8'h80};
        logic [WIDTH-1:0] vb [4] = '{8'h01, 8'h01, 8'h34, 8'h80};
        logic [WIDTH-1:0] vs [4] = '{8'h10, 8'h00, 8'h46, 8'h00};
        logic             vc [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        int nb, nd;
        for (int i = 0; i < 4; i++) begin
            do_op(va[i], vb[i], 1'b0, nb, nd);
            total++;
            if (sum !== vs[i] || cout !== vc[i]) begin
                bad++;
                $display("FAIL add_%0d: got sum=%h cout=%b want sum=%h cout=%b",
                         i, sum, cout, vs[i], vc[i]);
            end
            total++;
            if (nb != WIDTH || nd != 1) begin
                bad++;
                $display("FAIL add_timing_%0d: got busy=%0d done=%0d want busy=%0d done=1",
                         i, nb, nd, WIDTH);
            end
        end
`ifdef SERIAL_ADDER_OVF_EN
        do_op(8'h7F, 8'h01, 1'b0, nb, nd);
        total++;
        if (sum !== 8'h80 || ovf !== 1'b1) begin
            bad++;
            $display("FAIL add_ovf: got sum=%h ovf=%b want sum=80 ovf=1", sum, ovf);
        end
        do_op(8'h0F, 8'h01, 1'b0, nb, nd);
        total++;
        if (ovf !== 1'b0) begin
            bad++;
            $display("FAIL add_no_ovf: got ovf=%b want 0", ovf);
        end
`endif
    endtask

    task automatic test_sub;
        logic [WIDTH-1:0] va [3] = '{8'h05, 8'h07, 8'h10};
        logic [WIDTH-1:0] vb [3] = '{8'h07, 8'h07, 8'h01};
        logic [WIDTH-1:0] vs [3] = '{8'hFE, 8'h00, 8'h0F};
        logic             vc [3] = '{1'b0, 1'b1, 1'b1};
        int nb, nd;
        for (int i = 0; i < 3; i++) begin
            do_op(va[i], vb[i], 1'b1, nb, nd);
            total++;
            if (sum !== vs[i] || cout !== vc[i] || nd != 1) begin
                bad++;
                $display("FAIL sub_%0d: got sum=%h cout=%b done=%0d want sum=%h cout=%b done=1",
                         i, sum, cout, nd, vs[i], vc[i]);
            end
`ifdef SERIAL_ADDER_OVF_EN
            total++;
            if (ovf !== 1'b0) begin
                bad++;
                $display("FAIL sub_ovf_%0d: got ovf=%b want 0", i, ovf);
            end
`endif
        end
    endtask

    // Previous result is 0x0F (from 0x10-0x01); it must hold through RUN.
    task automatic test_start_ignored;
        int nb, nd;
        a = 8'h0F;
        b = 8'h01;
        sub = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        nb = 0;
        nd = 0;
        for (int i = 0; i < WIDTH + 4; i++) begin
            if (busy) nb++;
            if (done) nd++;
            if (i == 2) begin
                total++;
                if (sum !== 8'h0F || cout !== 1'b1) begin
                    bad++;
                    $display("FAIL hold_in_run: got sum=%h cout=%b want sum=0f cout=1",
                             sum, cout);
                end
                a = 8'hAA;
                b = 8'h55;
                sub = 1'b1;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        total++;
        if (sum !== 8'h10 || cout !== 1'b0 || nd != 1 || nb != WIDTH) begin
            bad++;
            $display("FAIL start_ignored: got sum=%h cout=%b done=%0d busy=%0d want sum=10 cout=0 done=1 busy=%0d",
                     sum, cout, nd, nb, WIDTH);
        end
    endtask

    task automatic test_reset_mid_run;
        int nb, nd;
        a = 8'hFF;
        b = 8'hFF;
        sub = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({busy, done, sum, cout} !== {2'b00, 8'h00, 1'b0}) begin
            bad++;
            $display("FAIL reset_mid_run: got busy=%b done=%b sum=%h cout=%b want all 0",
                     busy, done, sum, cout);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        nd = 0;
        for (int i = 0; i < WIDTH + 4; i++) begin
            if (done || busy) nd++;
            @(posedge clk);
            #1;
        end
        total++;
        if (nd != 0) begin
            bad++;
            $display("FAIL no_done_after_reset: got %0d active cycles want 0", nd);
        end
        // Start presented immediately after release: must be taken on the first edge.
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        do_op(8'h12, 8'h34, 1'b0, nb, nd);
        total++;
        if (sum !== 8'h46 || cout !== 1'b0 || nb != WIDTH || nd != 1) begin
            bad++;
            $display("FAIL op_after_reset: got sum=%h cout=%b busy=%0d done=%0d want sum=46 cout=0 busy=%0d done=1",
                     sum, cout, nb, nd, WIDTH);
        end
    endtask

    task automatic test_back_to_back;
        int last;
        int ndone;
        a = 8'h01;
        b = 8'h01;
        sub = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        last = -1;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                ndone++;
                total++;
                if (sum !== 8'h02 || (last < 0 && i != WIDTH) ||
                    (last >= 0 && i - last != WIDTH + 1)) begin
                    bad++;
                    $display("FAIL back_to_back: done at cycle %0d prev %0d sum=%h want period %0d sum=02",
                             i, last, sum, WIDTH + 1);
                end
                last = i;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        total++;
        if (ndone != 4) begin
            bad++;
            $display("FAIL back_to_back_count: got %0d done pulses want 4", ndone);
        end
        repeat (WIDTH + 2) @(posedge clk);
        #1;
    endtask

    initial begin
        #1;
        test_reset();
        test_add();
        test_sub();
        test_start_ignored();
        test_reset_mid_run();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
